// File: rtl/aes_pipe_scheduler_if.sv
// Requester and response bundle for the shared AES pipeline scheduler.
// master = requester/consumer side, slave = scheduler side.
interface aes_pipe_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_data;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/aes_pipe_scheduler.sv
// Round-robin issue of requester blocks into one pipelined AES core,
// in-order tag return, credit-limited response FIFO, key-change drain.
module aes_pipe_scheduler #(
  parameter int DATA_W    = 128,
  parameter int KEY_L     = 128,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int OUT_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_load,
  input  logic [KEY_L-1:0]  key_in,
  output logic              key_ready,
  aes_pipe_scheduler_if.slave bus,
  output logic              core_data_valid,
  output logic [DATA_W-1:0] core_plain,
  output logic              core_key_valid,
  output logic [KEY_L-1:0]  core_key,
  input  logic              core_valid_out,
  input  logic [DATA_W-1:0] core_cipher,
  output logic              err_unexp
);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int RW = ID_W + DATA_W;

  typedef enum logic [1:0] {
    S_NOKEY,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [KEY_L-1:0]  key_q, key_d;
  logic [KEY_L-1:0]  pend_q, pend_d;
  logic              kv_q, kv_d;
  logic              dv_q, dv_d;
  logic [DATA_W-1:0] plain_q, plain_d;
  logic [CW-1:0]     used_q, used_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic              err_q, err_d;

  logic [ID_W-1:0]   tag_mem_q [OUT_DEPTH];
  logic [PW-1:0]     tag_wp_q, tag_wp_d;
  logic [PW-1:0]     tag_rp_q, tag_rp_d;
  logic [CW-1:0]     tag_cnt_q, tag_cnt_d;

  logic [RW-1:0]     rsp_mem_q [OUT_DEPTH];
  logic [PW-1:0]     rsp_wp_q, rsp_wp_d;
  logic [PW-1:0]     rsp_rp_q, rsp_rp_d;
  logic [CW-1:0]     rsp_cnt_q, rsp_cnt_d;

  logic              found;
  logic [ID_W-1:0]   gnt;
  logic [DATA_W-1:0] plain_sel;
  logic              tag_empty;
  logic              can_issue;
  logic              hs;
  logic              pop;
  logic              ret;

  always_comb begin
    logic [ID_W:0] sum;
    sum   = '0;
    found = 1'b0;
    gnt   = rr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ))
        sum = sum - (ID_W+1)'(NUM_REQ);
      if (!found && bus.req_valid[sum[ID_W-1:0]]) begin
        found = 1'b1;
        gnt   = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    plain_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt == ID_W'(i))
        plain_sel = bus.req_data[i*DATA_W +: DATA_W];
  end

  assign tag_empty = (tag_cnt_q == '0);
  // a key_load in RUN already blocks the grant of its own cycle
  assign can_issue = (state_q == S_RUN) && !key_load
                   && (used_q < CW'(OUT_DEPTH));
  assign hs  = can_issue && found;
  assign pop = bus.resp_ready && (rsp_cnt_q != '0);
  assign ret = core_valid_out && !tag_empty;

  always_comb begin
    bus.req_ready = '0;
    if (hs)
      bus.req_ready[gnt] = 1'b1;
  end

  assign bus.resp_valid = (rsp_cnt_q != '0);
  assign {bus.resp_id, bus.resp_data} =
    bus.resp_valid ? rsp_mem_q[rsp_rp_q] : '0;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    pend_d    = pend_q;
    kv_d      = kv_q;
    dv_d      = hs;
    plain_d   = plain_q;
    rr_d      = rr_q;
    used_d    = used_q;
    err_d     = err_q | (core_valid_out & tag_empty);
    tag_wp_d  = tag_wp_q;
    tag_rp_d  = tag_rp_q;
    tag_cnt_d = tag_cnt_q;
    rsp_wp_d  = rsp_wp_q;
    rsp_rp_d  = rsp_rp_q;
    rsp_cnt_d = rsp_cnt_q;

    unique case (state_q)
      S_NOKEY: begin
        if (key_load) begin
          key_d   = key_in;
          kv_d    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (key_load) begin
          pend_d  = key_in;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!dv_q && tag_empty) begin
          key_d   = pend_q;
          state_d = S_RUN;
        end
      end
      default: state_d = S_NOKEY;
    endcase

    if (hs) begin
      plain_d  = plain_sel;
      tag_wp_d = tag_wp_q + PW'(1);
      rr_d     = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);
    end
    if (ret) begin
      tag_rp_d = tag_rp_q + PW'(1);
      rsp_wp_d = rsp_wp_q + PW'(1);
    end
    if (pop)
      rsp_rp_d = rsp_rp_q + PW'(1);

    unique case ({hs, ret})
      2'b10:   tag_cnt_d = tag_cnt_q + CW'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - CW'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase
    unique case ({ret, pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + CW'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - CW'(1);
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
    unique case ({hs, pop})
      2'b10:   used_d = used_q + CW'(1);
      2'b01:   used_d = used_q - CW'(1);
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hs)
      tag_mem_q[tag_wp_q] <= gnt;
    if (ret)
      rsp_mem_q[rsp_wp_q] <= {tag_mem_q[tag_rp_q], core_cipher};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_NOKEY;
      key_q     <= '0;
      pend_q    <= '0;
      kv_q      <= 1'b0;
      dv_q      <= 1'b0;
      plain_q   <= '0;
      used_q    <= '0;
      rr_q      <= '0;
      err_q     <= 1'b0;
      tag_wp_q  <= '0;
      tag_rp_q  <= '0;
      tag_cnt_q <= '0;
      rsp_wp_q  <= '0;
      rsp_rp_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      pend_q    <= pend_d;
      kv_q      <= kv_d;
      dv_q      <= dv_d;
      plain_q   <= plain_d;
      used_q    <= used_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
      tag_wp_q  <= tag_wp_d;
      tag_rp_q  <= tag_rp_d;
      tag_cnt_q <= tag_cnt_d;
      rsp_wp_q  <= rsp_wp_d;
      rsp_rp_q  <= rsp_rp_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  assign key_ready       = (state_q != S_DRAIN);
  assign core_data_valid = dv_q;
  assign core_plain      = plain_q;
  assign core_key_valid  = kv_q;
  assign core_key        = key_q;
  assign err_unexp       = err_q;
endmodule
